// File: rtl/rf_wr_sched_pkg.sv
// Shared constants and types for the register-file write-port scheduler.
// Default widths mirror the core's register bus and register address bus.
package rf_wr_sched_pkg;

    localparam int DEF_XLEN         = 32;
    localparam int DEF_REG_ADDR_W   = 5;
    localparam int DEF_REG_NUM      = 32;
    localparam int DEF_STARVE_LIMIT = 8;

    typedef enum logic [1:0] {
        SRC_NONE,
        SRC_EX,
        SRC_LSU,
        SRC_DBG
    } wr_src_e;

endpackage

// File: rtl/rf_wr_skid.sv
// One-entry valid/ready skid buffer holding a pending register write (addr+data).
// The entry drains whenever the downstream port is not stalled.
module rf_wr_skid #(
    parameter int AW = 5,
    parameter int DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_valid,
    input  logic [AW-1:0] i_addr,
    input  logic [DW-1:0] i_data,
    output logic          o_ready,
    input  logic          i_stall,
    output logic          o_valid,
    output logic          o_drain,
    output logic [AW-1:0] o_addr,
    output logic [DW-1:0] o_data
);

    logic          r_valid;
    logic [AW-1:0] r_addr;
    logic [DW-1:0] r_data;
    logic          w_drain;

    assign w_drain = r_valid & ~i_stall;
    assign o_ready = ~r_valid | w_drain;
    assign o_valid = r_valid;
    assign o_drain = w_drain;
    assign o_addr  = r_addr;
    assign o_data  = r_data;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= 1'b0;
            r_addr  <= '0;
            r_data  <= '0;
        end else if (i_valid && o_ready) begin
            r_valid <= 1'b1;
            r_addr  <= i_addr;
            r_data  <= i_data;
        end else if (w_drain) begin
            r_valid <= 1'b0;
        end
    end

endmodule

// File: rtl/rf_wr_sched.sv
// Register-file write-port arbiter (EX > buffered load > debug) with load scoreboard.
// Build option RF_DBG_PORT_EN enables the debug requester, starve counter and hold_o.
module rf_wr_sched
    import rf_wr_sched_pkg::*;
#(
    parameter int XLEN             = DEF_XLEN,
    parameter int REG_ADDR_W       = DEF_REG_ADDR_W,
    parameter int REG_NUM          = DEF_REG_NUM,
    parameter int DBG_STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ex_we_i,
    input  logic [REG_ADDR_W-1:0] ex_waddr_i,
    input  logic [XLEN-1:0]       ex_wdata_i,
    input  logic                  lsu_valid_i,
    input  logic [REG_ADDR_W-1:0] lsu_waddr_i,
    input  logic [XLEN-1:0]       lsu_wdata_i,
    output logic                  lsu_ready_o,
    input  logic                  dbg_valid_i,
    input  logic [REG_ADDR_W-1:0] dbg_waddr_i,
    input  logic [XLEN-1:0]       dbg_wdata_i,
    output logic                  dbg_ready_o,
    input  logic                  ld_issue_i,
    input  logic [REG_ADDR_W-1:0] ld_rd_i,
    input  logic [REG_ADDR_W-1:0] id_raddr1_i,
    input  logic [REG_ADDR_W-1:0] id_raddr2_i,
    input  logic [REG_ADDR_W-1:0] id_waddr_i,
    output logic                  hazard_o,
    output logic                  hold_o,
    output logic                  we_o,
    output logic [REG_ADDR_W-1:0] waddr_o,
    output logic [XLEN-1:0]       wdata_o
);

    logic                  w_buf_valid;
    logic                  w_buf_drain;
    logic [REG_ADDR_W-1:0] w_buf_addr;
    logic [XLEN-1:0]       w_buf_data;
    logic                  w_lsu_ready;
    logic                  w_dbg_grant;
    logic [REG_NUM-1:0]    r_busy;
    logic [REG_NUM-1:0]    w_busy_nxt;
    wr_src_e               w_src;
    logic [REG_ADDR_W-1:0] w_addr;
    logic [XLEN-1:0]       w_data;

    rf_wr_skid #(
        .AW (REG_ADDR_W),
        .DW (XLEN)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .i_valid (lsu_valid_i),
        .i_addr  (lsu_waddr_i),
        .i_data  (lsu_wdata_i),
        .o_ready (w_lsu_ready),
        .i_stall (ex_we_i),
        .o_valid (w_buf_valid),
        .o_drain (w_buf_drain),
        .o_addr  (w_buf_addr),
        .o_data  (w_buf_data)
    );

    assign lsu_ready_o = rst | w_lsu_ready;

`ifdef RF_DBG_PORT_EN
    localparam int CW = $clog2(DBG_STARVE_LIMIT + 1);

    logic [CW-1:0] r_starve;
    logic          r_hold;

    assign w_dbg_grant = ~rst & dbg_valid_i & ~ex_we_i & ~w_buf_valid;

    // hold_o stays up from the limit until the debug write is granted
    always_ff @(posedge clk) begin
        if (rst) begin
            r_starve <= '0;
            r_hold   <= 1'b0;
        end else if (dbg_valid_i && !w_dbg_grant) begin
            if (r_starve != CW'(DBG_STARVE_LIMIT))
                r_starve <= r_starve + 1'b1;
            if (r_starve >= CW'(DBG_STARVE_LIMIT - 1))
                r_hold <= 1'b1;
        end else begin
            r_starve <= '0;
            r_hold   <= 1'b0;
        end
    end

    assign hold_o = r_hold & ~rst;
`else
    localparam int lp_unused_limit = DBG_STARVE_LIMIT;

    logic w_dbg_unused;

    assign w_dbg_unused = ^{dbg_valid_i, dbg_waddr_i, dbg_wdata_i};
    assign w_dbg_grant  = 1'b0;
    assign hold_o       = 1'b0;
`endif

    assign dbg_ready_o = w_dbg_grant;

    always_comb begin
        w_src  = SRC_NONE;
        w_addr = '0;
        w_data = '0;
        if (!rst) begin
            if (ex_we_i) begin
                w_src  = SRC_EX;
                w_addr = ex_waddr_i;
                w_data = ex_wdata_i;
            end else if (w_buf_valid) begin
                w_src  = SRC_LSU;
                w_addr = w_buf_addr;
                w_data = w_buf_data;
            end else if (w_dbg_grant) begin
                w_src  = SRC_DBG;
                w_addr = dbg_waddr_i;
                w_data = dbg_wdata_i;
            end
        end
    end

    assign we_o    = (w_src != SRC_NONE) && (w_addr != '0);
    assign waddr_o = w_addr;
    assign wdata_o = w_data;

    // a new load to the same reg overrides the drain clearing it
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_buf_drain)
            w_busy_nxt[w_buf_addr] = 1'b0;
        if (ld_issue_i && ld_rd_i != '0)
            w_busy_nxt[ld_rd_i] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst)
            r_busy <= '0;
        else
            r_busy <= w_busy_nxt;
    end

    assign hazard_o = ~rst & (r_busy[id_raddr1_i]
                            | r_busy[id_raddr2_i]
                            | r_busy[id_waddr_i]);

    always_ff @(posedge clk) begin
        if (!rst) begin
            assert (!(ex_we_i && r_busy[ex_waddr_i]));
            assert (!(w_dbg_grant && r_busy[dbg_waddr_i]));
        end
    end

endmodule

// File: tb/tb_rf_wr_sched.sv
// Directed testbench for rf_wr_sched: arbitration, scoreboard, x0, starvation, reset.
// Debug expectations follow the RF_DBG_PORT_EN build option.
module tb_rf_wr_sched;

    logic        clk = 1'b0;
    logic        rst;
    logic        ex_we_i;
    logic [4:0]  ex_waddr_i;
    logic [31:0] ex_wdata_i;
    logic        lsu_valid_i;
    logic [4:0]  lsu_waddr_i;
    logic [31:0] lsu_wdata_i;
    logic        lsu_ready_o;
    logic        dbg_valid_i;
    logic [4:0]  dbg_waddr_i;
    logic [31:0] dbg_wdata_i;
    logic        dbg_ready_o;
    logic        ld_issue_i;
    logic [4:0]  ld_rd_i;
    logic [4:0]  id_raddr1_i;
    logic [4:0]  id_raddr2_i;
    logic [4:0]  id_waddr_i;
    logic        hazard_o;
    logic        hold_o;
    logic        we_o;
    logic [4:0]  waddr_o;
    logic [31:0] wdata_o;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    rf_wr_sched dut (
        .clk         (clk),
        .rst         (rst),
        .ex_we_i     (ex_we_i),
        .ex_waddr_i  (ex_waddr_i),
        .ex_wdata_i  (ex_wdata_i),
        .lsu_valid_i (lsu_valid_i),
        .lsu_waddr_i (lsu_waddr_i),
        .lsu_wdata_i (lsu_wdata_i),
        .lsu_ready_o (lsu_ready_o),
        .dbg_valid_i (dbg_valid_i),
        .dbg_waddr_i (dbg_waddr_i),
        .dbg_wdata_i (dbg_wdata_i),
        .dbg_ready_o (dbg_ready_o),
        .ld_issue_i  (ld_issue_i),
        .ld_rd_i     (ld_rd_i),
        .id_raddr1_i (id_raddr1_i),
        .id_raddr2_i (id_raddr2_i),
        .id_waddr_i  (id_waddr_i),
        .hazard_o    (hazard_o),
        .hold_o      (hold_o),
        .we_o        (we_o),
        .waddr_o     (waddr_o),
        .wdata_o     (wdata_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic idle();
        ex_we_i     = 1'b0;
        ex_waddr_i  = '0;
        ex_wdata_i  = '0;
        lsu_valid_i = 1'b0;
        lsu_waddr_i = '0;
        lsu_wdata_i = '0;
        dbg_valid_i = 1'b0;
        dbg_waddr_i = '0;
        dbg_wdata_i = '0;
        ld_issue_i  = 1'b0;
        ld_rd_i     = '0;
        id_raddr1_i = '0;
        id_raddr2_i = '0;
        id_waddr_i  = '0;
    endtask

    task automatic wr(input string tag, input logic we,
                      input logic [4:0] a, input logic [31:0] d);
        chk({tag, "_we"}, 32'(we), 32'(we_o));
        if (we) begin
            chk({tag, "_addr"}, 32'(waddr_o), 32'(a));
            chk({tag, "_data"}, wdata_o, d);
        end
    endtask

    initial begin
        logic dbg_on;
`ifdef RF_DBG_PORT_EN
        dbg_on = 1'b1;
`else
        dbg_on = 1'b0;
`endif
        idle();
        rst = 1'b1;

        // reset with every requester active
        ex_we_i = 1'b1; ex_waddr_i = 5; ex_wdata_i = 32'h11;
        lsu_valid_i = 1'b1; lsu_waddr_i = 6; lsu_wdata_i = 32'h22;
        dbg_valid_i = 1'b1; dbg_waddr_i = 9; dbg_wdata_i = 32'h99;
        ld_issue_i = 1'b1; ld_rd_i = 7; id_raddr1_i = 7;
        tick();
        tick();
        chk("rst_we", 32'(we_o), 32'd0);
        chk("rst_lsu_rdy", 32'(lsu_ready_o), 32'd1);
        chk("rst_hazard", 32'(hazard_o), 32'd0);
        chk("rst_dbg_rdy", 32'(dbg_ready_o), 32'd0);
        chk("rst_hold", 32'(hold_o), 32'd0);
        chk("rst_waddr", 32'(waddr_o), 32'd0);
        chk("rst_wdata", wdata_o, 32'd0);
        idle();
        id_raddr1_i = 7;
        rst = 1'b0;
        settle();
        chk("post_rst_hazard", 32'(hazard_o), 32'd0);
        chk("post_rst_we", 32'(we_o), 32'd0);
        tick();

        // EX and LSU clash, EX idle the next cycle
        idle();
        ex_we_i = 1'b1; ex_waddr_i = 5; ex_wdata_i = 32'h11;
        lsu_valid_i = 1'b1; lsu_waddr_i = 6; lsu_wdata_i = 32'h22;
        settle();
        wr("clash_ex", 1'b1, 5, 32'h11);
        chk("clash_rdy0", 32'(lsu_ready_o), 32'd1);
        tick();
        idle();
        settle();
        wr("clash_lsu", 1'b1, 6, 32'h22);
        chk("clash_rdy1", 32'(lsu_ready_o), 32'd1);
        tick();

        // clash with EX still busy the next cycle
        ex_we_i = 1'b1; ex_waddr_i = 5; ex_wdata_i = 32'h11;
        lsu_valid_i = 1'b1; lsu_waddr_i = 6; lsu_wdata_i = 32'h33;
        tick();
        idle();
        ex_we_i = 1'b1; ex_waddr_i = 5; ex_wdata_i = 32'h44;
        settle();
        wr("busy_ex", 1'b1, 5, 32'h44);
        chk("busy_rdy", 32'(lsu_ready_o), 32'd0);
        tick();
        idle();
        settle();
        wr("busy_lsu", 1'b1, 6, 32'h33);
        tick();
        settle();
        wr("idle", 1'b0, 0, 0);

        // scoreboard
        ld_issue_i = 1'b1; ld_rd_i = 7; id_raddr1_i = 7;
        settle();
        chk("sb_pre", 32'(hazard_o), 32'd0);
        tick();
        ld_issue_i = 1'b0;
        settle();
        chk("sb_set", 32'(hazard_o), 32'd1);
        id_raddr1_i = 0; id_waddr_i = 7;
        settle();
        chk("sb_waddr", 32'(hazard_o), 32'd1);
        id_waddr_i = 0; id_raddr2_i = 7;
        settle();
        chk("sb_raddr2", 32'(hazard_o), 32'd1);
        id_raddr2_i = 0; id_raddr1_i = 7;
        lsu_valid_i = 1'b1; lsu_waddr_i = 7; lsu_wdata_i = 32'h77;
        tick();
        lsu_valid_i = 1'b0;
        settle();
        chk("sb_drain_hz", 32'(hazard_o), 32'd1);
        wr("sb_drain", 1'b1, 7, 32'h77);
        tick();
        chk("sb_clear", 32'(hazard_o), 32'd0);
        idle();

        // debug starvation under continuous EX
        ex_we_i = 1'b1; ex_waddr_i = 1; ex_wdata_i = 32'h1;
        dbg_valid_i = 1'b1; dbg_waddr_i = 9; dbg_wdata_i = 32'hDEAD;
        settle();
        chk("dbg_wait_rdy", 32'(dbg_ready_o), 32'd0);
        for (int i = 0; i < 7; i++) tick();
        chk("dbg_hold7", 32'(hold_o), 32'd0);
        tick();
        chk("dbg_hold8", 32'(hold_o), 32'(dbg_on));
        ex_we_i = 1'b0;
        settle();
        chk("dbg_grant", 32'(dbg_ready_o), 32'(dbg_on));
        wr("dbg_wr", dbg_on, 9, 32'hDEAD);
        chk("dbg_hold_g", 32'(hold_o), 32'(dbg_on));
        tick();
        idle();
        settle();
        chk("dbg_hold_clr", 32'(hold_o), 32'd0);

        // x0 targets
        lsu_valid_i = 1'b1; lsu_waddr_i = 0; lsu_wdata_i = 32'h55;
        settle();
        chk("x0_lsu_rdy", 32'(lsu_ready_o), 32'd1);
        tick();
        idle();
        settle();
        chk("x0_lsu_we", 32'(we_o), 32'd0);
        tick();
        dbg_valid_i = 1'b1; dbg_waddr_i = 0; dbg_wdata_i = 32'h66;
        settle();
        chk("x0_dbg_rdy", 32'(dbg_ready_o), 32'(dbg_on));
        chk("x0_dbg_we", 32'(we_o), 32'd0);
        tick();
        idle();
        ld_issue_i = 1'b1; ld_rd_i = 0;
        tick();
        ld_issue_i = 1'b0;
        settle();
        chk("x0_busy", 32'(hazard_o), 32'd0);

        // set and clear of x3 in the same cycle
        ld_issue_i = 1'b1; ld_rd_i = 3; id_raddr1_i = 3;
        tick();
        ld_issue_i = 1'b0;
        lsu_valid_i = 1'b1; lsu_waddr_i = 3; lsu_wdata_i = 32'h3;
        tick();
        lsu_valid_i = 1'b0;
        ld_issue_i = 1'b1; ld_rd_i = 3;
        settle();
        wr("race_drain", 1'b1, 3, 32'h3);
        tick();
        ld_issue_i = 1'b0;
        settle();
        chk("race_busy", 32'(hazard_o), 32'd1);

        // reset with a load still buffered
        lsu_valid_i = 1'b1; lsu_waddr_i = 3; lsu_wdata_i = 32'h99;
        ex_we_i = 1'b1; ex_waddr_i = 2; ex_wdata_i = 32'h2;
        tick();
        idle();
        id_raddr1_i = 3;
        rst = 1'b1;
        settle();
        chk("rst_mid_we", 32'(we_o), 32'd0);
        tick();
        rst = 1'b0;
        settle();
        chk("rst_mid_we2", 32'(we_o), 32'd0);
        chk("rst_mid_hz", 32'(hazard_o), 32'd0);
        tick();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
